// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: maskable edge/level channels plus one NMI,
// with a two-state acknowledge sequencer that freezes the vector while INTACK is high.
module interrupt_controller #(
  parameter int unsigned       N_CH         = 8,
  parameter logic [N_CH-1:0]   EDGE_MASK    = '1,
  parameter logic [N_CH-1:0]   AUTOCLR_MASK = '1,
  parameter logic [5:0]        VEC_BASE     = 6'd32,
  parameter logic [5:0]        NMI_VEC      = 6'd62
) (
  input  logic            MCLK,
  input  logic            reset_n,
  input  logic [N_CH-1:0] irq_in,
  input  logic            nmi_in,
  input  logic            sfr_we,
  input  logic [1:0]      sfr_addr,
  input  logic [15:0]     sfr_wdata,
  output logic [15:0]     sfr_rdata,
  input  logic            INTACK,
  output logic            NMI,
  output logic            INT,
  output logic [5:0]      IntAddrLSBs,
  output logic [4:0]      ack_ch,
  output logic            o_dbg_state
);

  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N_CH-1:0] r_ie;
  logic [N_CH-1:0] r_ifg;
  logic [N_CH-1:0] r_irq_d;
  logic            r_nmiifg;
  logic            r_nmie;
  logic            r_nmi_d;
  logic            r_armed;
  logic [4:0]      r_ack_ch;
  logic [5:0]      r_vec;

  logic [N_CH-1:0] w_pend;
  logic [N_CH-1:0] w_edge;
  logic [N_CH-1:0] w_hw_set;
  logic [N_CH-1:0] w_win_oh;
  logic [N_CH-1:0] w_ack_clr;
  logic [N_CH-1:0] w_ifg_nxt;
  logic            w_nmi_pend;
  logic            w_nmi_edge;
  logic            w_win_any;
  logic [4:0]      w_win_ch;
  logic [5:0]      w_win_vec;
  logic            w_ack_take;
  logic            w_nmiifg_nxt;
  logic            w_nmie_nxt;
  logic            w_unused_wdata;

  assign w_unused_wdata = ^sfr_wdata;

  assign w_pend     = r_ie & r_ifg;
  assign w_nmi_pend = r_nmiifg & r_nmie;

  // r_armed stays low for the first sample after reset so an input already high is not an edge
  assign w_edge     = {N_CH{r_armed}} & ~r_irq_d & irq_in;
  assign w_hw_set   = (w_edge & EDGE_MASK) | (irq_in & ~EDGE_MASK);
  assign w_nmi_edge = r_armed & ~r_nmi_d & nmi_in;

  always_comb begin
    w_win_any = 1'b0;
    w_win_ch  = 5'd0;
    w_win_vec = 6'd0;
    w_win_oh  = '0;
    if (w_nmi_pend) begin
      w_win_any = 1'b1;
      w_win_ch  = 5'd16;
      w_win_vec = NMI_VEC;
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        if (w_pend[i]) begin
          w_win_any   = 1'b1;
          w_win_ch    = 5'(i);
          w_win_vec   = VEC_BASE + 6'(i);
          w_win_oh    = '0;
          w_win_oh[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_take  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (INTACK) begin
          w_ack_take  = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!INTACK) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_ack_clr = {N_CH{w_ack_take}} & w_win_oh & AUTOCLR_MASK;

  // Hardware sets are applied last so they win over software and acknowledge clears
  always_comb begin
    w_ifg_nxt = r_ifg;
    if (sfr_we && sfr_addr == 2'd1) w_ifg_nxt = sfr_wdata[N_CH-1:0];
    if (sfr_we && sfr_addr == 2'd2) w_ifg_nxt = w_ifg_nxt & ~sfr_wdata[N_CH-1:0];
    w_ifg_nxt = (w_ifg_nxt & ~w_ack_clr) | w_hw_set;

    w_nmiifg_nxt = r_nmiifg;
    w_nmie_nxt   = r_nmie;
    if (sfr_we && sfr_addr == 2'd3) begin
      if (sfr_wdata[0]) w_nmiifg_nxt = 1'b0;
      w_nmie_nxt = sfr_wdata[1];
    end
    if (w_ack_take && w_nmi_pend) begin
      w_nmiifg_nxt = 1'b0;
      w_nmie_nxt   = 1'b0;
    end
    w_nmiifg_nxt = w_nmiifg_nxt | w_nmi_edge;
  end

  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_ie     <= '0;
      r_ifg    <= '0;
      r_irq_d  <= '0;
      r_nmiifg <= 1'b0;
      r_nmie   <= 1'b0;
      r_nmi_d  <= 1'b0;
      r_armed  <= 1'b0;
      r_ack_ch <= 5'd0;
      r_vec    <= 6'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_ifg    <= w_ifg_nxt;
      r_nmiifg <= w_nmiifg_nxt;
      r_nmie   <= w_nmie_nxt;
      r_irq_d  <= irq_in;
      r_nmi_d  <= nmi_in;
      r_armed  <= 1'b1;
      if (sfr_we && sfr_addr == 2'd0) r_ie <= sfr_wdata[N_CH-1:0];
      if (w_ack_take) begin
        r_ack_ch <= w_win_ch;
        r_vec    <= w_win_vec;
      end
    end
  end

  always_comb begin
    sfr_rdata = 16'h0000;
    case (sfr_addr)
      2'd0:    sfr_rdata = 16'(r_ie);
      2'd1:    sfr_rdata = 16'(r_ifg);
      2'd3:    sfr_rdata = {14'd0, r_nmie, r_nmiifg};
      default: sfr_rdata = 16'h0000;
    endcase
  end

  assign NMI         = w_nmi_pend;
  assign INT         = |w_pend;
  assign IntAddrLSBs = (r_state == ST_HOLD) ? r_vec : w_win_vec;
  assign ack_ch      = r_ack_ch;
  assign o_dbg_state = r_state;

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 The block SHALL take parameter N_CH, default 8, giving the number of maskable channels (legal 1..16).
REQ-002 The block SHALL take parameter EDGE_MASK, default all-ones, where bit i=1 makes channel i rising-edge triggered and bit i=0 makes it level triggered.
REQ-003 The block SHALL take parameter AUTOCLR_MASK, default all-ones, where bit i=1 clears IFG[i] on acknowledge.
REQ-004 The block SHALL take parameter VEC_BASE, default 6'd32, giving the vector LSBs of channel 0 (channel i uses VEC_BASE+i).
REQ-005 The block SHALL take parameter NMI_VEC, default 6'd62, giving the NMI vector LSBs; VEC_BASE+N_CH SHALL be <= NMI_VEC.
REQ-006 MCLK  in  1  system clock; all state changes on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 irq_in  in  N_CH  peripheral interrupt requests, synchronous to MCLK.
REQ-009 nmi_in  in  1  non-maskable request, rising-edge triggered.
REQ-010 sfr_we  in  1  register write strobe.
REQ-011 sfr_addr  in  2  register select (0 IE, 1 IFG, 2 IFG-clear, 3 NMI control).
REQ-012 sfr_wdata  in  16  write data.
REQ-013 sfr_rdata  out  16  read data, combinational from sfr_addr, zero-extended.
REQ-014 INTACK  in  1  CPU interrupt acknowledge, high for one or more cycles.
REQ-015 NMI  out  1  non-maskable request to the CPU.
REQ-016 INT  out  1  maskable request to the CPU.
REQ-017 IntAddrLSBs  out  6  vector address bits [6:1].
REQ-018 ack_ch  out  5  index of the last acknowledged source (16 = NMI).

Function
REQ-019 IE[N_CH-1:0] SHALL be a read/write register at addr 0.
REQ-020 IFG SHALL be readable at addr 1, and a write to addr 1 SHALL load IFG directly.
REQ-021 A write to addr 2 SHALL clear every IFG bit written as 1; addr 2 SHALL read as zero.
REQ-022 Addr 3 SHALL expose NMIIFG in bit 0 (write-1-clear) and NMIE in bit 1 (read/write).
REQ-023 An edge channel SHALL set IFG[i] on the cycle after irq_in[i] samples 0 then 1.
REQ-024 A level channel SHALL set IFG[i] every cycle in which irq_in[i]=1.
REQ-025 A rising edge on nmi_in SHALL set NMIIFG.
REQ-026 A hardware set SHALL win over a software clear or an acknowledge-clear in the same cycle.
REQ-027 NMI SHALL equal NMIIFG & NMIE; INT SHALL equal |(IE & IFG); both SHALL be combinational from registers.
REQ-028 Priority SHALL be NMI highest, then channel N_CH-1 down to channel 0.
REQ-029 FSM states: IDLE and HOLD.
REQ-030 In IDLE, IntAddrLSBs SHALL show the current winner's vector, or 0 if none is pending.
REQ-031 In IDLE, on a posedge with INTACK=1, the block SHALL latch the winner into ack_ch and the held vector, then enter HOLD.
- If the winner is NMI: NMIIFG and NMIE cleared.
- If the winner is maskable and AUTOCLR_MASK[i]=1: IFG[i] cleared.
REQ-032 In HOLD, IntAddrLSBs SHALL stay at the latched vector regardless of new requests.
REQ-033 The block SHALL return to IDLE on the first posedge with INTACK=0.
REQ-034 INTACK with no request pending SHALL latch vector 0 and ack_ch 0, and SHALL clear nothing.
REQ-035 Flags SHALL continue to set normally during HOLD.

Reset
REQ-036 reset_n low SHALL immediately clear IE, IFG, NMIIFG, NMIE, the edge-detect history, ack_ch, and the held vector, and SHALL force IDLE.
REQ-037 While in reset, NMI, INT, IntAddrLSBs and sfr_rdata SHALL all read 0.
REQ-038 Reset asserted during HOLD SHALL abort the acknowledge with no flag side effects after release.
REQ-039 After reset release, an input already high SHALL NOT count as an edge, because edge history resets to the current-high-blind value 0 then samples; the first sample only arms the detector.

Verification
REQ-040 Edge priority:
- Stimulus: IE=0x00FF; pulse irq_in[2] and irq_in[5] together.
- Required: INT=1, IntAddrLSBs=37.
- Then INTACK for 2 cycles: vector held at 37, IFG=0x0004, ack_ch=5.
- After INTACK drops: IntAddrLSBs=34.
REQ-041 NMI preemption:
- Stimulus: NMIE=1 with IFG[7] pending; rising edge on nmi_in.
- Required: NMI=1, IntAddrLSBs=62.
- After INTACK: NMIIFG=0, NMIE=0, IFG[7] still 1.
REQ-042 Level, no auto-clear (AUTOCLR_MASK bit0=0):
- Stimulus: irq_in[0] held high; INTACK.
- Required: IFG[0] stays 1.
- Then deassert irq_in[0] and write 0x0001 to addr 2: IFG[0]=0, INT=0.
REQ-043 Set/clear collision:
- Stimulus: an irq_in[3] edge on the same cycle as an addr-2 write of 0x0008.
- Required: IFG[3]=1.
REQ-044 Reset mid-acknowledge:
- Stimulus: assert reset_n=0 during HOLD.
- Required: all outputs 0 asynchronously.
- After release: IDLE, and no spurious edge from an irq_in held high.
